// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider slice.
//   div_state_t   : FSM encoding (IDLE/CALC/FIX/DONE)
//   DIV_WIDTH     : operand/result width
//   DIV_CNT_W     : iteration counter width
//   DIV_ZERO_QUOT : quotient reported for a zero divisor
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/_32bit_adder.sv
// Datapath add/sub unit, reused by the divider as its trial subtractor.
//   a, b      : operands
//   op        : 0 = a + b + carry_in, 1 = a + ~b + carry_in (subtract with carry_in=1)
//   carry_in  : carry into bit 0
//   sum       : result
//   carry_out : carry out of the MSB (in subtract mode: 1 = no borrow)
module _32bit_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff = op ? ~b : b;
    {carry_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
  end

endmodule

// File: rtl/seq_divider_32.sv
// Multi-cycle restoring divider serving div/divu (quotient -> LO, remainder -> HI).
// One quotient bit per cycle; trial subtraction through _32bit_adder.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : request, sampled only in IDLE
//   is_signed             : 1 = div, 0 = divu (captured with start)
//   dividend, divisor     : operands (captured with start)
//   busy                  : high whenever not IDLE
//   done                  : one-cycle pulse when results are valid
//   quotient, remainder   : results, updated only at the FIX edge
//   div_by_zero, ovf      : flags, updated with the results
module seq_divider_32
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             ovf
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH-1:0] div_mag;
  logic [WIDTH-1:0] dividend_raw;
  logic             neg_q;
  logic             neg_r;
  logic             dz_pend;
  logic             ovf_pend;

  // Operand conditioning at capture time
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             ovf_case;

  always_comb begin
    a_neg    = is_signed & dividend[WIDTH-1];
    b_neg    = is_signed & divisor[WIDTH-1];
    a_mag    = a_neg ? (~dividend + WIDTH'(1)) : dividend;
    b_mag    = b_neg ? (~divisor + WIDTH'(1)) : divisor;
    ovf_case = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
  end

  // One restoring step: shift the next dividend bit into the partial remainder,
  // then try to subtract. The bit shifted out of r (r_msb) means the shifted
  // value already exceeds the divisor, so the subtraction must succeed.
  logic             r_msb;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] trial;
  logic             no_borrow;
  logic             take;

  assign r_msb = r[WIDTH-1];
  assign r_sh  = {r[WIDTH-2:0], q_shift[WIDTH-1]};
  assign take  = r_msb | no_borrow;

  _32bit_adder #(
    .WIDTH(WIDTH)
  ) u_trial_sub (
    .a         (r_sh),
    .b         (div_mag),
    .op        (1'b1),
    .carry_in  (1'b1),
    .sum       (trial),
    .carry_out (no_borrow)
  );

  // Sign restoration for the final results
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    q_fix = neg_q ? (~q_shift + WIDTH'(1)) : q_shift;
    r_fix = neg_r ? (~r + WIDTH'(1)) : r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      r            <= '0;
      q_shift      <= '0;
      div_mag      <= '0;
      dividend_raw <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dz_pend      <= 1'b0;
      ovf_pend     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r            <= '0;
            q_shift      <= a_mag;
            div_mag      <= b_mag;
            dividend_raw <= dividend;
            neg_q        <= a_neg ^ b_neg;
            neg_r        <= a_neg;
            dz_pend      <= (divisor == '0);
            ovf_pend     <= ovf_case;
            cnt          <= '0;
            busy         <= 1'b1;
            state        <= S_CALC;
          end
        end
        S_CALC: begin
          r       <= take ? trial : r_sh;
          q_shift <= {q_shift[WIDTH-2:0], take};
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (dz_pend) begin
            quotient  <= WIDTH'(DIV_ZERO_QUOT);
            remainder <= dividend_raw;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
          div_by_zero <= dz_pend;
          ovf         <= ovf_pend;
          done        <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32.sv
module tb_seq_divider_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        ovf;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [31:0] prev_q;

  seq_divider_32 #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_dz;
    logic        exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and follow it for 40 cycles after the start edge.
  // Sample index k = cycles after the start edge, sampled 1 time unit after the edge.
  task automatic run_op(input vec_t v);
    int unsigned busy_cnt;
    int unsigned done_cnt;
    int          done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    @(negedge clk);
    is_signed = v.sgn;
    dividend  = v.a;
    divisor   = v.b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 10) chk({v.name, " held_q"}, quotient, prev_q);
    end
    chk({v.name, " q"}, quotient, v.exp_q);
    chk({v.name, " r"}, remainder, v.exp_r);
    chk({v.name, " dz"}, 32'(div_by_zero), 32'(v.exp_dz));
    chk({v.name, " ovf"}, 32'(ovf), 32'(v.exp_ovf));
    chk({v.name, " done_at"}, 32'(done_at), 32'd33);
    chk({v.name, " done_cnt"}, 32'(done_cnt), 32'd1);
    chk({v.name, " busy_cycles"}, 32'(busy_cnt), 32'd34);
    prev_q = v.exp_q;
  endtask

  vec_t vecs[10];

  initial begin
    vec_t v;
    int   done_seen;
    n_cmp  = 0;
    n_bad  = 0;
    prev_q = 32'h0;

    vecs[0] = '{"divu_100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0};
    vecs[1] = '{"div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{"div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0};
    vecs[3] = '{"divu_25_0",    1'b0, 32'd25,        32'd0,         32'hFFFF_FFFF, 32'd25,        1'b1, 1'b0};
    vecs[4] = '{"div_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 1'b1};
    vecs[5] = '{"divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 1'b0};
    vecs[6] = '{"div_m100_m7",  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[7] = '{"div_m5_0",     1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0};
    vecs[8] = '{"divu_max_16",  1'b0, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 32'd15,        1'b0, 1'b0};
    vecs[9] = '{"divu_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset q", quotient, 32'd0);
    chk("reset r", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // A second start pulse while busy must be ignored
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd90;
    divisor   = 32'd10;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    dividend = 32'd5;
    divisor  = 32'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 60 && done_seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) done_seen = 1;
    end
    chk("busy_start done_seen", 32'(done_seen), 32'd1);
    chk("busy_start q", quotient, 32'd9);
    chk("busy_start r", remainder, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("busy_start no_restart", 32'(busy), 32'd0);

    // start held high through DONE: next op only begins from IDLE
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    repeat (33) @(posedge clk);
    #1;
    chk("held done_pulse", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    chk("held idle_gap", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("held restart", 32'(busy), 32'd1);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 60 && done_seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) done_seen = 1;
    end
    chk("held second q", quotient, 32'd14);
    chk("held second r", remainder, 32'd2);
    repeat (2) @(posedge clk);
    prev_q = 32'd14;

    // Asynchronous reset during CALC
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd500;
    divisor   = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst busy", 32'(busy), 32'd0);
    chk("async_rst done", 32'(done), 32'd0);
    chk("async_rst q", quotient, 32'd0);
    chk("async_rst r", remainder, 32'd0);
    chk("async_rst flags", {30'd0, div_by_zero, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen = 1;
    end
    chk("async_rst no_done", 32'(done_seen), 32'd0);
    prev_q = 32'd0;
    v = '{"post_rst_max_1", 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0};
    run_op(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
